// File: rtl/alu_op_sequencer.sv
// Registered, valid/ready ALU opcode decoder with a latency counter for multi-cycle M-extension ops.
// Build option: define ALU_OP_SEQ_MEXT_EN to enable M-extension decode, the BUSY state and mc_start.
module alu_op_sequencer #(
    parameter int OP_W    = 5,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic            is_imm,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] Operation,
    output logic            illegal,
    output logic            mc_start
);
    // Handshake: a transfer happens on a rising edge where valid && ready; the producer holds its
    // payload stable while valid is high and ready is low.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, OUT = 2'd2} state_t;

    localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_XOR  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011, OP_AND  = 5'b00100, OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SLL  = 5'b00110, OP_SRA  = 5'b00111, OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001, OP_PASSB = 5'b11000;
    localparam logic [6:0] F7_ZERO = 7'b0000000, F7_ALT = 7'b0100000, F7_MEXT = 7'b0000001;
    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  op_q;
    logic        ill_q;
    logic [4:0]  dec_op;
    logic        dec_ill, dec_mc, load;
    logic [7:0]  dec_cnt;

    function automatic logic [4:0] std_op(input logic [2:0] f3);
        case (f3)
            3'b000:  std_op = OP_ADD;
            3'b001:  std_op = OP_SLL;
            3'b010:  std_op = OP_SLT;
            3'b011:  std_op = OP_SLTU;
            3'b100:  std_op = OP_XOR;
            3'b101:  std_op = OP_SRL;
            3'b110:  std_op = OP_OR;
            default: std_op = OP_AND;
        endcase
    endfunction

    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        dec_mc  = 1'b0;
        dec_cnt = Funct3[2] ? DIV_CNT : MUL_CNT;
        case (ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b11: dec_op = OP_PASSB;
            2'b01: begin
                // Branch compares occupy 01010..01111 in Funct3 order, skipping the 010/011 holes.
                if (Funct3 == 3'b010 || Funct3 == 3'b011) dec_ill = 1'b1;
                else if (Funct3[2]) dec_op = {2'b01, 1'b1, Funct3[1:0]};
                else dec_op = {2'b01, 2'b01, Funct3[0]};
            end
            default: begin
                if (is_imm) begin
                    if (Funct3 == 3'b001) begin
                        if (Funct7 == F7_ZERO) dec_op = OP_SLL;
                        else dec_ill = 1'b1;
                    end else if (Funct3 == 3'b101) begin
                        if (Funct7 == F7_ZERO) dec_op = OP_SRL;
                        else if (Funct7 == F7_ALT) dec_op = OP_SRA;
                        else dec_ill = 1'b1;
                    end else begin
                        dec_op = std_op(Funct3);
                    end
                end else if (Funct7 == F7_ZERO) begin
                    dec_op = std_op(Funct3);
                end else if (Funct7 == F7_ALT) begin
                    if (Funct3 == 3'b000) dec_op = OP_SUB;
                    else if (Funct3 == 3'b101) dec_op = OP_SRA;
                    else dec_ill = 1'b1;
                end else if (Funct7 == F7_MEXT) begin
`ifdef ALU_OP_SEQ_MEXT_EN
                    dec_op = {2'b10, Funct3};
                    dec_mc = 1'b1;
`else
                    dec_ill = 1'b1;
`endif
                end else begin
                    dec_ill = 1'b1;
                end
            end
        endcase
        if (dec_ill) dec_op = OP_ADD;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            BUSY: begin
                if (cnt_q == 8'd0) state_d = OUT;
                else cnt_d = cnt_q - 8'd1;
            end
            OUT: begin
                in_ready = out_ready;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over everything, including an instruction offered in the same cycle.
        if (flush) begin
            in_ready = 1'b0;
            state_d  = IDLE;
            cnt_d    = 8'd0;
        end else if (in_ready && in_valid) begin
            load    = 1'b1;
            state_d = dec_mc ? BUSY : OUT;
            cnt_d   = dec_mc ? dec_cnt : 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            op_q    <= OP_ADD;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                op_q  <= dec_op;
                ill_q <= dec_ill;
            end
        end
    end

`ifdef ALU_OP_SEQ_MEXT_EN
    logic mc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mc_q <= 1'b0;
        else mc_q <= load && dec_mc;
    end
    assign mc_start = mc_q;
`else
    assign mc_start = 1'b0;
`endif

    assign out_valid = (state_q == OUT);
    assign Operation = OP_W'(op_q);
    assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus random traffic against a
// transaction-level reference (decode rules + "cycles until result" bookkeeping).
module tb_alu_op_sequencer;
    localparam int OP_W    = 5;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;
`ifdef ALU_OP_SEQ_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif
    // Operation codes by Funct3 for branches (-1 = illegal) and for the plain R/I table.
    localparam int BR_TAB[8]  = '{10, 11, -1, -1, 12, 13, 14, 15};
    localparam int STD_TAB[8] = '{0, 6, 8, 9, 2, 5, 3, 4};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      ALUOp = 2'b00;
    logic            is_imm = 1'b0;
    logic [6:0]      Funct7 = 7'd0;
    logic [2:0]      Funct3 = 3'd0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OP_W-1:0] Operation;
    logic            illegal;
    logic            mc_start;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: an accepted op becomes visible after busy_left more cycles.
    bit have_out = 0;
    int busy_left = 0;
    int exp_op = 0;
    bit exp_ill = 0;
    bit exp_mc = 0;

    alu_op_sequencer #(.OP_W(OP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .is_imm(is_imm), .Funct7(Funct7), .Funct3(Funct3),
        .out_valid(out_valid), .out_ready(out_ready), .Operation(Operation),
        .illegal(illegal), .mc_start(mc_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] a, input bit imm, input logic [6:0] f7,
                                       input logic [2:0] f3, output int op, output bit ill,
                                       output int lat);
        op = 0; ill = 0; lat = 0;
        if (a == 2'b00) op = 0;
        else if (a == 2'b11) op = 24;
        else if (a == 2'b01) begin
            if (BR_TAB[f3] < 0) ill = 1;
            else op = BR_TAB[f3];
        end else if (imm) begin
            if (f3 == 3'd1 && f7 != 7'h00) ill = 1;
            else if (f3 == 3'd5 && f7 == 7'h20) op = 7;
            else if (f3 == 3'd5 && f7 != 7'h00) ill = 1;
            else op = STD_TAB[f3];
        end else if (f7 == 7'h00) op = STD_TAB[f3];
        else if (f7 == 7'h20) begin
            if (f3 == 3'd0) op = 1;
            else if (f3 == 3'd5) op = 7;
            else ill = 1;
        end else if (f7 == 7'h01 && MEXT) begin
            op  = 16 + int'(f3);
            lat = (f3 >= 3'd4) ? DIV_LAT : MUL_LAT;
        end else ill = 1;
        if (ill) op = 0;
    endfunction

    // One clock: drive inputs after the edge, check mid-cycle, then advance the reference.
    task automatic step(input bit iv, input logic [1:0] a, input bit imm, input logic [6:0] f7,
                        input logic [2:0] f3, input bit ordy, input bit fl);
        bit exp_ov, exp_ir, ill;
        int op, lat;
        @(posedge clk);
        #1;
        in_valid = iv; ALUOp = a; is_imm = imm; Funct7 = f7; Funct3 = f3;
        out_ready = ordy; flush = fl;
        @(negedge clk);
        exp_ov = have_out && (busy_left == 0);
        exp_ir = !fl && (!have_out || (exp_ov && ordy));
        check("out_valid", out_valid, exp_ov);
        check("in_ready", in_ready, exp_ir);
        check("mc_start", mc_start, exp_mc);
        if (exp_ov) begin
            check("operation", Operation, exp_op);
            check("illegal", illegal, exp_ill);
        end
        exp_mc = 0;
        if (fl) begin
            have_out = 0;
            busy_left = 0;
        end else if (exp_ir && iv) begin
            ref_decode(a, imm, f7, f3, op, ill, lat);
            have_out = 1; exp_op = op; exp_ill = ill; busy_left = lat; exp_mc = (lat > 0);
        end else if (exp_ov && ordy) begin
            have_out = 0;
        end else if (busy_left > 0) begin
            busy_left--;
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 2'b00, 1'b0, 7'h00, 3'd0, ordy, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_operation"}, Operation, 0);
        check({tag, "_illegal"}, illegal, 1'b0);
        check({tag, "_mc_start"}, mc_start, 1'b0);
    endtask

    initial begin
        logic [6:0] f7_pick;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // R-type SUB, then ALU logic ops streamed one per cycle.
        step(1'b1, 2'b10, 1'b0, 7'h20, 3'd0, 1'b1, 1'b0);
        step(1'b1, 2'b10, 1'b0, 7'h00, 3'd4, 1'b1, 1'b0);
        step(1'b1, 2'b10, 1'b0, 7'h00, 3'd6, 1'b1, 1'b0);
        step(1'b1, 2'b10, 1'b0, 7'h00, 3'd7, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // DIV through the latency counter.
        step(1'b1, 2'b10, 1'b0, 7'h01, 3'd4, 1'b1, 1'b0);
        repeat (DIV_LAT + 2) idle(1'b1);

        // BNE under backpressure with a competing instruction offered.
        step(1'b1, 2'b01, 1'b0, 7'h00, 3'd1, 1'b1, 1'b0);
        repeat (5) step(1'b1, 2'b10, 1'b0, 7'h00, 3'd0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Immediate forms: ADDI ignores Funct7, SLLI with a non-zero Funct7 is illegal.
        step(1'b1, 2'b10, 1'b1, 7'h20, 3'd0, 1'b1, 1'b0);
        step(1'b1, 2'b10, 1'b1, 7'h20, 3'd1, 1'b1, 1'b0);
        step(1'b1, 2'b10, 1'b1, 7'h20, 3'd5, 1'b1, 1'b0);
        step(1'b1, 2'b01, 1'b0, 7'h00, 3'd2, 1'b1, 1'b0);
        step(1'b1, 2'b11, 1'b0, 7'h00, 3'd0, 1'b1, 1'b0);
        idle(1'b1);

        // Flush on the tenth cycle of a DIV, with an instruction offered alongside.
        step(1'b1, 2'b10, 1'b0, 7'h01, 3'd4, 1'b1, 1'b0);
        repeat (9) idle(1'b1);
        step(1'b1, 2'b10, 1'b0, 7'h00, 3'd0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset in the middle of a DIV.
        step(1'b1, 2'b10, 1'b0, 7'h01, 3'd6, 1'b1, 1'b0);
        repeat (5) idle(1'b1);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        have_out = 0; busy_left = 0; exp_mc = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, with MUL/DIV and the alternate Funct7 weighted up.
        repeat (3000) begin
            case ($urandom_range(0, 3))
                0: f7_pick = 7'h00;
                1: f7_pick = 7'h20;
                2: f7_pick = 7'h01;
                default: f7_pick = 7'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), f7_pick,
                 3'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end
        repeat (DIV_LAT + 2) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
